aula_20201105_qsys_nios2_qsys_ic_ocimem_seq: RTL and testbench

AULA_20201105_QSYS_NIOS2_QSYS_IC_OCIMEM_SEQ -- requirements
Module: aula_20201105_qsys_nios2_qsys_ic_ocimem_seq

---
 rtl/aula_20201105_qsys_nios2_qsys_ic_ocimem_seq.sv | 131 +++++++++++++
 tb/tb_aula_20201105_qsys_nios2_qsys_ic_ocimem_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aula_20201105_qsys_nios2_qsys_ic_ocimem_seq.sv
// Debug on-chip-memory access sequencer.
// Turns the ocimem action strobes from the JTAG debug system-clock stage into
// single-word read/write accesses on the 256-word debug RAM. It keeps the
// debug address/data registers and reports ready/error status to the monitor.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a strobe; the only state where strobes are taken
// RD_REQ  | mem_read held until the RAM accepts it or the stall limit hits
// RD_DATA | read data arrives; capture it and bump the address
// WR_REQ  | mem_write held until the RAM accepts it or the stall limit hits
module aula_20201105_qsys_nios2_qsys_ic_ocimem_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic [7:0]  MonAReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic [7:0]  mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DATA = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       in_req;
    logic       timeout_hit;
    logic       any_strobe;
    logic       err_set;
    logic       err_clr;
    logic       jdo_unused;

    // Top jdo bits carry nothing for this block.
    assign jdo_unused = ^jdo[37:36];

    // Address and write data are only looked at while a request is raised,
    // and the registers they mirror are stable for the whole request.
    assign mem_address   = MonAReg;
    assign mem_writedata = MonDReg;

    assign in_req      = (state == RD_REQ) || (state == WR_REQ);
    // The current stalled cycle is the TIMEOUT-th consecutive one.
    assign timeout_hit = in_req && mem_waitrequest && (wait_cnt == 8'(TIMEOUT - 1));
    assign any_strobe  = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
    // A strobe outside IDLE is an overrun; the access in flight is left alone.
    assign err_set     = ((state != IDLE) && any_strobe) || timeout_hit;
    assign err_clr     = (state == IDLE) && take_action_ocimem_a && jdo[35];

    // Next-state decode; strobe priority is a > b > no_action_a.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    if (jdo[34]) state_nxt = RD_REQ;
                end else if (take_action_ocimem_b) begin
                    state_nxt = WR_REQ;
                end else if (take_no_action_ocimem_a) begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!mem_waitrequest) state_nxt = RD_DATA;
                else if (timeout_hit) state_nxt = IDLE;
            end
            RD_DATA: state_nxt = IDLE;
            WR_REQ: begin
                if (!mem_waitrequest || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered status/request outputs, stall counter and debug registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            MonDReg       <= '0;
            MonAReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            monitor_ready <= (state_nxt == IDLE);
            mem_read      <= (state_nxt == RD_REQ);
            mem_write     <= (state_nxt == WR_REQ);

            if (state_nxt != state) wait_cnt <= '0;
            else if (in_req && mem_waitrequest) wait_cnt <= wait_cnt + 8'd1;

            if (err_set) monitor_error <= 1'b1;
            else if (err_clr) monitor_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) MonAReg <= jdo[33:26];
                    else if (take_action_ocimem_b) MonDReg <= jdo[34:3];
                end
                RD_DATA: begin
                    MonDReg <= mem_readdata;
                    MonAReg <= MonAReg + 8'd1;
                end
                WR_REQ: begin
                    if (!mem_waitrequest) MonAReg <= MonAReg + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aula_20201105_qsys_nios2_qsys_ic_ocimem_seq.sv
// Bench for the ocimem sequencer: a RAM with scripted stalls, a transaction
// level model of the debug registers and RAM, and per-cycle bus checks.
module tb_aula_20201105_qsys_nios2_qsys_ic_ocimem_seq;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    aula_20201105_qsys_nios2_qsys_ic_ocimem_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .MonDReg(MonDReg),
        .MonAReg(MonAReg),
        .monitor_ready(monitor_ready),
        .monitor_error(monitor_error),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ram     [256];
    logic [31:0] exp_ram [256];
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    logic        exp_err;
    logic [7:0]  cur_addr;
    logic [31:0] cur_data;
    int          stall_n = 0;
    int          stall_cnt = 0;
    int          run_len = 0;
    int          last_req_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // RAM: readdata one cycle after acceptance; writes land on acceptance.
    always @(posedge clk) begin
        if (mem_read && !mem_waitrequest) mem_readdata <= ram[mem_address];
        if (mem_write && !mem_waitrequest) ram[mem_address] <= mem_writedata;
    end

    // Stall script: each request sees stall_n stalled cycles before acceptance.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            mem_waitrequest = (stall_cnt < stall_n);
            stall_cnt++;
        end else begin
            mem_waitrequest = 1'b0;
            stall_cnt = 0;
        end
    end

    // Per-cycle bus checks and request-length measurement.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            run_len++;
            chk("rd_wr_exclusive", {31'd0, mem_read && mem_write}, 32'd0);
            chk("req_address", {24'd0, mem_address}, {24'd0, cur_addr});
            if (mem_write) chk("req_writedata", mem_writedata, cur_data);
        end else if (run_len != 0) begin
            last_req_len = run_len;
            run_len = 0;
        end
    end

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a, 3 = ocimem_a + ocimem_b.
    // inject != 0 pulses ocimem_b on that cycle after the strobe.
    task automatic access(input int kind, input logic [37:0] j, input int stalls, input int inject);
        bit acc;
        bit is_rd;
        bit tmo;
        int lat;
        int k;
        acc = 1'b1;
        is_rd = 1'b1;
        if (kind == 0 || kind == 3) begin
            exp_a = j[33:26];
            if (j[35]) exp_err = 1'b0;
            acc = j[34];
        end else if (kind == 1) begin
            exp_d = j[34:3];
            is_rd = 1'b0;
        end
        cur_addr = exp_a;
        cur_data = exp_d;
        stall_n = stalls;
        last_req_len = 0;
        jdo = j;
        take_action_ocimem_a = (kind == 0 || kind == 3);
        take_action_ocimem_b = (kind == 1 || kind == 3);
        take_no_action_ocimem_a = (kind == 2);
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        k = 1;
        if (acc) begin
            while (!monitor_ready && k < 400) begin
                take_action_ocimem_b = (k == inject);
                if (k == inject) jdo = {$urandom, $urandom};
                @(negedge clk);
                k++;
            end
            take_action_ocimem_b = 1'b0;
            #1;
            tmo = (stalls >= TIMEOUT);
            if (tmo) begin
                exp_err = 1'b1;
                lat = 1 + TIMEOUT;
                chk("req_len", last_req_len, TIMEOUT);
            end else begin
                if (is_rd) begin
                    exp_d = exp_ram[exp_a];
                    lat = 3 + stalls;
                end else begin
                    exp_ram[exp_a] = exp_d;
                    lat = 2 + stalls;
                end
                exp_a = exp_a + 8'd1;
                chk("req_len", last_req_len, stalls + 1);
            end
            if (inject != 0) exp_err = 1'b1;
            chk("latency", k, lat);
        end else begin
            @(negedge clk);
            chk("no_access_ready", {31'd0, monitor_ready}, 32'd1);
            chk("no_access_read", {31'd0, mem_read || mem_write}, 32'd0);
        end
        chk("MonAReg", {24'd0, MonAReg}, {24'd0, exp_a});
        chk("MonDReg", MonDReg, exp_d);
        chk("monitor_error", {31'd0, monitor_error}, {31'd0, exp_err});
        chk("monitor_ready", {31'd0, monitor_ready}, 32'd1);
    endtask

    function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [7:0] addr);
        return {2'b00, clr, rd, addr, 26'd0};
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        return {3'b000, data, 3'b000};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_MonDReg"}, MonDReg, 32'd0);
        chk({tag, "_MonAReg"}, {24'd0, MonAReg}, 32'd0);
        chk({tag, "_ready"}, {31'd0, monitor_ready}, 32'd1);
        chk({tag, "_error"}, {31'd0, monitor_error}, 32'd0);
        chk({tag, "_rd_wr"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({tag, "_addr"}, {24'd0, mem_address}, 32'd0);
        chk({tag, "_wdata"}, mem_writedata, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            exp_ram[i] = ram[i];
        end
        ram[8'h10] = 32'hDEADBEEF;
        exp_ram[8'h10] = 32'hDEADBEEF;
        exp_a = 8'd0;
        exp_d = 32'd0;
        exp_err = 1'b0;
        cur_addr = 8'd0;
        cur_data = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic read with no stall.
        access(0, jdo_a(1'b0, 1'b1, 8'h10), 0, 0);
        chk("pin_read_data", MonDReg, 32'hDEADBEEF);
        chk("pin_read_addr", {24'd0, MonAReg}, 32'h11);

        // Write at 0xFF with 3 stalls, address wraps, then a streaming read.
        access(0, jdo_a(1'b0, 1'b0, 8'hFF), 0, 0);
        access(1, jdo_b(32'h12345678), 3, 0);
        chk("pin_wrap_addr", {24'd0, MonAReg}, 32'h00);
        chk("pin_wr_len", last_req_len, 4);
        access(2, '0, 0, 0);

        // Stuck waitrequest: abort after TIMEOUT request cycles.
        access(0, jdo_a(1'b0, 1'b1, 8'h40), 255, 0);
        chk("pin_tmo_addr", {24'd0, MonAReg}, 32'h40);
        chk("pin_tmo_err", {31'd0, monitor_error}, 32'd1);

        // Overrun during a read, then clear with no access.
        access(0, jdo_a(1'b1, 1'b1, 8'h20), 3, 2);
        chk("pin_overrun_err", {31'd0, monitor_error}, 32'd1);
        access(0, jdo_a(1'b1, 1'b0, 8'h55), 0, 0);
        chk("pin_clear_err", {31'd0, monitor_error}, 32'd0);

        // Simultaneous a and b: only the address load.
        access(3, jdo_a(1'b0, 1'b0, 8'h77) | 38'h0000_0000_78, 0, 0);

        // Reset during a stalled write.
        exp_d = 32'hCAFEF00D;
        cur_data = exp_d;
        cur_addr = exp_a;
        stall_n = 255;
        jdo = jdo_b(32'hCAFEF00D);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("stalled_write_active", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        reset = 1'b0;
        exp_a = 8'd0;
        exp_d = 32'd0;
        exp_err = 1'b0;
        cur_addr = 8'd0;
        cur_data = 32'd0;
        stall_n = 0;
        @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int kind;
            int st;
            int inj;
            logic [37:0] j;
            kind = $urandom_range(0, 3);
            st = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            inj = ($urandom_range(0, 5) == 0) ? 1 : 0;
            j = {$urandom, $urandom};
            if (kind == 0 && $urandom_range(0, 3) == 0) j[33:26] = 8'hFF;
            if ((kind == 0 || kind == 3) && !j[34]) inj = 0;
            if (kind == 3) j[34] = 1'b0;
            if (kind == 3) inj = 0;
            access(kind, j, st, inj);
        end

        // RAM contents written by the DUT against the model.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== exp_ram[i]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ram[%0d]: got %h, expected %h", i, ram[i], exp_ram[i]);
            end else begin
                n_cmp++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
